// File: rtl/cg_pkg.sv
// Shared types and default sizing for the per-domain clock-gating controller.
package cg_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_GATED = 2'd1,
        CG_WAKE  = 2'd2
    } cg_state_e;

    localparam int CG_N_DOM    = 4;
    localparam int CG_CNT_W    = 8;
    localparam int CG_WAKE_LAT = 2;

endpackage

// File: rtl/cg_ctrl_if.sv
// Domain-facing bundle: busy/wake handshake in, gating-cell controls and status out.
interface cg_ctrl_if #(
    parameter int N_DOM = 4
);

    logic [N_DOM-1:0] busy;
    logic [N_DOM-1:0] wake_req;
    logic [N_DOM-1:0] wake_ack;
    logic [N_DOM-1:0] active_o;
    logic [N_DOM-1:0] bypass_o;
    logic [N_DOM-1:0] gated_o;

    // master = the gated domains and their cells, slave = the controller
    modport master (
        output busy, wake_req,
        input  wake_ack, active_o, bypass_o, gated_o
    );

    modport slave (
        input  busy, wake_req,
        output wake_ack, active_o, bypass_o, gated_o
    );

endinterface

// File: rtl/cg_domain_fsm.sv
// One gated domain: idle counter, RUN/GATED/WAKE sequencing, settle timer and
// registered gating-cell controls.
module cg_domain_fsm
    import cg_pkg::*;
#(
    parameter int CNT_W    = CG_CNT_W,
    parameter int WAKE_LAT = CG_WAKE_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             wake_req,
    input  logic             cfg_bypass,
    input  logic             force_on,
    input  logic [CNT_W-1:0] idle_thresh,
    output logic             active,
    output logic             bypass,
    output logic             gated,
    output logic             wake_ack
);

    localparam int              SET_W    = $clog2(WAKE_LAT + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(WAKE_LAT - 1);

    cg_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [SET_W-1:0] settle;

    logic             idle;
    logic             frc;
    logic             hit;
    logic [CNT_W:0]   cnt_inc;

    assign idle    = ~busy & ~wake_req;
    assign frc     = cfg_bypass | force_on;
    // One extra bit so a saturated count plus one still compares above any threshold.
    assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign hit     = idle & ~frc & (idle_thresh != '0) & (cnt_inc >= {1'b0, idle_thresh});

    // NOTE: every state element is assigned with <= so all registers update
    // from the same pre-edge values; blocking assignments here would race.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CG_RUN;
            cnt      <= '0;
            settle   <= '0;
            active   <= 1'b1;
            bypass   <= 1'b0;
            gated    <= 1'b0;
            wake_ack <= 1'b0;
        end else begin
            bypass <= frc;
            unique case (state)
                CG_RUN: begin
                    if (hit) begin
                        state    <= CG_GATED;
                        cnt      <= '0;
                        active   <= 1'b0;
                        gated    <= 1'b1;
                        wake_ack <= 1'b0;
                    end else begin
                        if (!idle || frc) cnt <= '0;
                        else if (!(&cnt)) cnt <= cnt_inc[CNT_W-1:0];
                        wake_ack <= wake_req;
                    end
                end
                CG_GATED: begin
                    cnt      <= '0;
                    wake_ack <= 1'b0;
                    if (wake_req || busy || frc) begin
                        state  <= CG_WAKE;
                        settle <= '0;
                        active <= 1'b1;
                        gated  <= 1'b0;
                    end
                end
                CG_WAKE: begin
                    cnt <= '0;
                    if (settle == SET_LAST) begin
                        state    <= CG_RUN;
                        wake_ack <= wake_req;
                    end else begin
                        settle   <= settle + SET_W'(1);
                        wake_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= CG_RUN;
                    active   <= 1'b1;
                    gated    <= 1'b0;
                    wake_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cg_ctrl.sv
// Clock-gating controller for N_DOM domains; one cg_domain_fsm per domain with
// the global force and the shared idle threshold fanned out to all of them.
module cg_ctrl
    import cg_pkg::*;
#(
    parameter int N_DOM    = CG_N_DOM,
    parameter int CNT_W    = CG_CNT_W,
    parameter int WAKE_LAT = CG_WAKE_LAT
) (
    input  logic             raw_clk,
    input  logic             rst,
    cg_ctrl_if.slave         bus,
    input  logic [CNT_W-1:0] idle_thresh,
    input  logic [N_DOM-1:0] cfg_bypass,
    input  logic             force_on
);

    logic [N_DOM-1:0] active_v;
    logic [N_DOM-1:0] bypass_v;
    logic [N_DOM-1:0] gated_v;
    logic [N_DOM-1:0] ack_v;

    for (genvar i = 0; i < N_DOM; i++) begin : g_dom
        cg_domain_fsm #(
            .CNT_W    (CNT_W),
            .WAKE_LAT (WAKE_LAT)
        ) u_dom (
            .clk         (raw_clk),
            .rst         (rst),
            .busy        (bus.busy[i]),
            .wake_req    (bus.wake_req[i]),
            .cfg_bypass  (cfg_bypass[i]),
            .force_on    (force_on),
            .idle_thresh (idle_thresh),
            .active      (active_v[i]),
            .bypass      (bypass_v[i]),
            .gated       (gated_v[i]),
            .wake_ack    (ack_v[i])
        );
    end

    assign bus.active_o = active_v;
    assign bus.bypass_o = bypass_v;
    assign bus.gated_o  = gated_v;
    assign bus.wake_ack = ack_v;

endmodule

// File: tb/tb_cg_ctrl.sv
// Self-checking bench for cg_ctrl: cycle model feeds a scoreboard queue, plus
// directed timing checks at the points where exact edges matter.
module tb_cg_ctrl;

    localparam int N_DOM    = 4;
    localparam int CNT_W    = 8;
    localparam int WAKE_LAT = 2;

    logic             raw_clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] idle_thresh;
    logic [N_DOM-1:0] cfg_bypass;
    logic             force_on;

    cg_ctrl_if #(.N_DOM(N_DOM)) bus ();

    cg_ctrl #(
        .N_DOM    (N_DOM),
        .CNT_W    (CNT_W),
        .WAKE_LAT (WAKE_LAT)
    ) dut (
        .raw_clk     (raw_clk),
        .rst         (rst),
        .bus         (bus.slave),
        .idle_thresh (idle_thresh),
        .cfg_bypass  (cfg_bypass),
        .force_on    (force_on)
    );

    always #5 raw_clk = ~raw_clk;

    typedef struct packed {
        logic [N_DOM-1:0] act;
        logic [N_DOM-1:0] byp;
        logic [N_DOM-1:0] gat;
        logic [N_DOM-1:0] ack;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0=run 1=gated 2=wake, unbounded idle run length,
    // settle expressed as cycles remaining.
    int   mode    [N_DOM];
    int   run_len [N_DOM];
    int   left    [N_DOM];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        e = '0;
        for (int i = 0; i < N_DOM; i++) begin
            bit idle, frc;
            int thr;
            idle = !bus.busy[i] && !bus.wake_req[i];
            frc  = cfg_bypass[i] || force_on;
            thr  = int'(idle_thresh);
            if (rst) begin
                mode[i] = 0; run_len[i] = 0; left[i] = 0;
                e.ack[i] = 1'b0;
                e.byp[i] = 1'b0;
            end else begin
                e.byp[i] = frc;
                case (mode[i])
                    0: begin
                        if (idle && !frc && thr != 0 && run_len[i] + 1 >= thr) begin
                            mode[i] = 1; run_len[i] = 0; e.ack[i] = 1'b0;
                        end else begin
                            run_len[i] = (idle && !frc) ? run_len[i] + 1 : 0;
                            e.ack[i] = bus.wake_req[i];
                        end
                    end
                    1: begin
                        e.ack[i] = 1'b0;
                        if (bus.wake_req[i] || bus.busy[i] || frc) begin
                            mode[i] = 2; left[i] = WAKE_LAT;
                        end
                    end
                    default: begin
                        left[i]--;
                        e.ack[i] = 1'b0;
                        if (left[i] == 0) begin
                            mode[i] = 0; run_len[i] = 0; e.ack[i] = bus.wake_req[i];
                        end
                    end
                endcase
            end
            e.act[i] = (mode[i] != 1);
            e.gat[i] = (mode[i] == 1);
        end
        q.push_back(e);
    endtask

    // One clock: predict from the inputs about to be sampled, then compare #1 after the edge.
    task automatic tick();
        exp_t e;
        model_step();
        @(posedge raw_clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            check("sb_active", 32'(bus.active_o), 32'(e.act));
            check("sb_bypass", 32'(bus.bypass_o), 32'(e.byp));
            check("sb_gated",  32'(bus.gated_o),  32'(e.gat));
            check("sb_ack",    32'(bus.wake_ack), 32'(e.ack));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        idle_thresh  = 8'd4;
        cfg_bypass   = '0;
        force_on     = 1'b0;
        bus.busy     = '0;
        bus.wake_req = '0;

        // Reset state
        tick();
        check("rst_active", 32'(bus.active_o), 32'hF);
        check("rst_gated",  32'(bus.gated_o),  32'h0);
        check("rst_bypass", 32'(bus.bypass_o), 32'h0);
        check("rst_ack",    32'(bus.wake_ack), 32'h0);
        rst = 1'b0;

        // Idle gating after exactly 4 idle cycles
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) check("idle_run_active0", 32'(bus.active_o[0]), 32'd1);
        end
        check("idle_gate_active0", 32'(bus.active_o[0]), 32'd0);
        check("idle_gate_gated0",  32'(bus.gated_o[0]),  32'd1);

        // Wake handshake on domain 1
        bus.wake_req = 4'b0010;
        tick();
        check("wake_active1", 32'(bus.active_o[1]), 32'd1);
        check("wake_ack1_e1", 32'(bus.wake_ack[1]), 32'd0);
        tick();
        check("wake_ack1_e2", 32'(bus.wake_ack[1]), 32'd0);
        tick();
        check("wake_ack1_e3", 32'(bus.wake_ack[1]), 32'd1);
        tick();
        check("wake_ack1_hold", 32'(bus.wake_ack[1]), 32'd1);
        bus.wake_req = '0;
        tick();
        check("wake_ack1_drop", 32'(bus.wake_ack[1]), 32'd0);

        // Periodic busy on domain 2 keeps it from gating
        for (int c = 0; c < 30; c++) begin
            bus.busy[2] = (c % 3 == 0);
            tick();
        end
        check("busy_nogate2", 32'(bus.gated_o[2]), 32'd0);
        bus.busy = '0;
        for (int k = 0; k < 6; k++) tick();
        check("all_gated", 32'(bus.gated_o), 32'hF);

        // Global force reopens everything and holds it open
        force_on = 1'b1;
        tick();
        check("force_bypass", 32'(bus.bypass_o), 32'hF);
        check("force_active", 32'(bus.active_o), 32'hF);
        for (int k = 0; k < 10; k++) tick();
        check("force_nogate", 32'(bus.gated_o), 32'h0);
        force_on = 1'b0;

        // Threshold 0 disables gating; a later small threshold gates at once
        idle_thresh = 8'd0;
        for (int k = 0; k < 300; k++) tick();
        check("thresh0_nogate", 32'(bus.gated_o), 32'h0);
        idle_thresh = 8'd5;
        tick();
        check("sat_gate", 32'(bus.gated_o), 32'hF);

        // Reset while domain 3 is waking
        idle_thresh  = 8'd4;
        bus.wake_req = 4'b1000;
        tick();
        rst = 1'b1;
        tick();
        check("rstwake_active", 32'(bus.active_o), 32'hF);
        check("rstwake_ack",    32'(bus.wake_ack), 32'h0);
        check("rstwake_gated",  32'(bus.gated_o),  32'h0);
        rst = 1'b0;
        tick();
        check("rstwake_run_ack3", 32'(bus.wake_ack[3]), 32'd1);
        bus.wake_req = '0;
        tick();

        // Randomised traffic checked against the model
        for (int c = 0; c < 400; c++) begin
            if (c % 25 == 0) idle_thresh = 8'($urandom_range(0, 6));
            for (int i = 0; i < N_DOM; i++) begin
                bus.busy[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) bus.wake_req[i] = ~bus.wake_req[i];
                cfg_bypass[i] = ($urandom_range(0, 15) == 0);
            end
            force_on = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cg_ctrl.md
Name: cg_ctrl

Overview:
Per-domain clock-gating controller driving the `active`/`bypass` inputs of N BB_clk_gating cells. It watches each domain's busy indication and gates the domain after a programmable run of idle cycles. It reopens the clock on a wake request and acknowledges the requester only after a fixed settle latency. It sits in the always-on clock domain beside the gating cells.

Parameters:
N_DOM, 4, number of gated domains
CNT_W, 8, idle counter / threshold width
WAKE_LAT, 2, cycles clock is enabled before wake_ack (>=1)

Ports:
raw_clk  input  1  ungated controller clock
rst  input  1  synchronous, active-high reset
busy  input  N_DOM  domain i has work in flight
wake_req  input  N_DOM  level request to run domain i; held until wake_ack seen
wake_ack  output  N_DOM  domain i clock running and settled
idle_thresh  input  CNT_W  consecutive idle cycles before gating; 0 = gating disabled
cfg_bypass  input  N_DOM  per-domain force clock on
force_on  input  1  global force clock on, all domains
active_o  output  N_DOM  to gating cell `active`
bypass_o  output  N_DOM  to gating cell `bypass`
gated_o  output  N_DOM  status: domain i currently gated

Behaviour:
- All outputs registered; one raw_clk cycle from input to output.
- Reset (rst=1 at edge):
  - every domain goes to RUN;
  - active_o=all 1s (clocks on out of reset);
  - bypass_o=0, wake_ack=0, gated_o=0;
  - idle counters=0.
  - Reset mid-gate reopens all clocks on the next edge.
- Per-domain idle condition: idle_i = !busy[i] & !wake_req[i]. Forced condition: frc_i = cfg_bypass[i] | force_on.
- Per-domain FSM states: RUN, GATED, WAKE.
- RUN (active=1, gated=0):
  - counter resets to 0 if !idle_i or frc_i; otherwise it increments and saturates at all-ones.
  - Go to GATED when idle_i & !frc_i & idle_thresh!=0 & (cnt+1)>=idle_thresh. With thresh=T, active_o drops on the edge ending the T-th consecutive idle cycle.
  - idle_thresh is compared live. Lowering it below the current count gates on the next idle cycle.
- GATED (active=0, gated=1):
  - counter is held at 0.
  - Any of wake_req[i], busy[i] or frc_i takes the domain to WAKE. active_o rises on that edge.
- WAKE (active=1, gated=0):
  - settle counter runs 0..WAKE_LAT-1, then the domain goes to RUN.
  - wake_ack is never asserted while in WAKE.
- wake_ack[i] is registered: 1 when next state is RUN and wake_req[i]=1, else 0. From GATED, ack rises WAKE_LAT+1 edges after req is sampled high. In RUN, ack rises 1 edge after req.
- wake_req dropping during WAKE: WAKE completes to RUN, no ack, and the idle count restarts.
- bypass_o[i] = registered frc_i.
- Simultaneous idle-threshold hit and frc_i: frc_i wins, stay RUN.
- Simultaneous wake_req and threshold hit: wake_req makes idle_i=0, stay RUN.
- Width rules:
  - counter compare is done at CNT_W+1 bits so saturation never wraps;
  - WAKE settle counter width is $clog2(WAKE_LAT+1).

Decomposition:
- Package cg_pkg:
  - state enum cg_state_e {CG_RUN, CG_GATED, CG_WAKE} (2 bits);
  - localparam defaults for CNT_W and WAKE_LAT.
- Sub-module cg_domain_fsm: one domain (FSM, idle counter, settle counter, registered outputs), instantiated N_DOM times by a generate loop in cg_ctrl.
- cg_ctrl only fans out force_on and shared idle_thresh.

Test Plan:
- Reset release, busy=0, wake_req=0, thresh=4 -> active_o[0]=1 for 4 cycles, 0 after the 4th; gated_o[0]=1.
- Gated domain 1, wake_req[1] pulsed high and held, WAKE_LAT=2 -> active_o[1]=1 next edge; wake_ack[1]=1 exactly 3 edges after req sampled; req drop -> ack 0 next edge.
- busy[2] toggles 1 every 3rd cycle, thresh=4 -> never gates; counter restarts each busy pulse.
- force_on=1 while domains 0..3 gated -> all go to WAKE; bypass_o=4'hF next edge; no gating while force_on stays high.
- thresh=0 with idle inputs for 300 cycles -> never gated; then thresh=5 with counter saturated at 255 -> gates on next idle cycle.
- rst asserted during WAKE on domain 3 -> next edge active_o=4'hF, wake_ack=0, gated_o=0, FSM in RUN.
